// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: FSM states, RV64I
// load/store funct3 codes and small decode helpers.
package mau_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LDRESP = 3'd2,
    MERGE  = 3'd3,
    WR     = 3'd4,
    ERR    = 3'd5
  } mau_state_e;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // Stores have no unsigned variants; loads have no 8-byte unsigned variant.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    logic r;
    if (we) begin
      r = f3[2];
    end else begin
      r = (f3 == 3'b111);
    end
    return r;
  endfunction

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic r;
    case (sz)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      2'b10:   r = |off[1:0];
      2'b11:   r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Byte-lane mask covering the access size, anchored at lane 0.
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    logic [63:0] m;
    case (sz)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      2'b11:   m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane alignment: extracts and extends load data from a
// 64-bit little-endian memory word, and merges narrow store data into it.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merge_data
);

  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] lane_mask;

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shamt   = {off, 3'b000};
    shifted = rdata >> shamt;
    case (funct3)
      LB:      load_data = {{56{shifted[7]}},  shifted[7:0]};
      LH:      load_data = {{48{shifted[15]}}, shifted[15:0]};
      LW:      load_data = {{32{shifted[31]}}, shifted[31:0]};
      LD:      load_data = shifted;
      LBU:     load_data = {56'd0, shifted[7:0]};
      LHU:     load_data = {48'd0, shifted[15:0]};
      LWU:     load_data = {32'd0, shifted[31:0]};
      default: load_data = 64'd0;
    endcase
  end

  // Replace only the addressed lanes of the read word with the low store bytes.
  always_comb begin
    lane_mask  = size_mask(funct3[1:0]) << {off, 3'b000};
    merge_data = (rdata & ~lane_mask) | ((wdata << {off, 3'b000}) & lane_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit for an RV64I pipeline. Accepts one request in
// IDLE, performs a read, a read-modify-write, a full write or an error
// completion, and returns a single-cycle response pulse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [63:0]       mem_address,
  output logic [63:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [63:0]       mem_read_data
);

  mau_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;

  logic              req_bad;
  logic [63:0]       load_data;
  logic [63:0]       merge_data;

  mau_lane_align u_align (
    .funct3     (funct3_q),
    .off        (addr_q[2:0]),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // State and request latches; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 64'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next state: classify the request on acceptance, then walk the access sequence.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_bad  = is_illegal(req_we, req_funct3) ||
               is_misaligned(req_funct3[1:0], req_addr[2:0]);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_bad) begin
            state_d = ERR;
          end else if (!req_we) begin
            state_d = RD;
          end else begin
            case (req_funct3)
              SB, SH, SW: state_d = RD;
              SD:         state_d = WR;
              default:    state_d = ERR;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (we_q) begin
          state_d = MERGE;
        end else begin
          state_d = LDRESP;
        end
      end
      LDRESP:  state_d = IDLE;
      MERGE:   state_d = IDLE;
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on the registered state and latches (plus read data in LDRESP/MERGE).
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 64'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = 64'd0;
    mem_address    = 64'(addr_q);
    case (state_q)
      IDLE: req_ready = 1'b1;
      RD:   mem_read  = 1'b1;
      LDRESP: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
      end
      MERGE: begin
        mem_write      = 1'b1;
        mem_write_data = merge_data;
        resp_valid     = 1'b1;
      end
      WR: begin
        mem_write      = 1'b1;
        mem_write_data = wdata_q;
        resp_valid     = 1'b1;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small word-addressed memory
// model. Inputs change on the falling edge; outputs are sampled there too.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_read_data;

  logic [63:0] mem [0:31];
  logic        load_en;
  logic [4:0]  load_idx;
  logic [63:0] load_val;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word index = byte address / 8, combinational read
  assign mem_read_data = mem[mem_address[7:3]];

  // Memory model write port, with a bench-side preload path
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_val;
    end else if (mem_write) begin
      mem[mem_address[7:3]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge; it is accepted at the next rising edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    @(negedge clk);
    chk("ready_before_issue", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Directed sequence
  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    load_en    = 1'b0;
    load_idx   = 5'd0;
    load_val   = 64'd0;
    #2;
    rst = 1'b0;

    // Preload memory while reset is held
    @(negedge clk);
    load_en  = 1'b1;
    load_idx = 5'd8;
    load_val = 64'h8877_6655_4433_2211;
    @(negedge clk);
    load_idx = 5'd16;
    load_val = 64'd0;
    @(negedge clk);
    load_en = 1'b0;

    // Reset state
    chk("rst_req_ready",  {63'd0, req_ready},  64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err",   {63'd0, resp_err},   64'd0);
    chk("rst_resp_rdata", resp_rdata,          64'd0);
    chk("rst_mem_read",   {63'd0, mem_read},   64'd0);
    chk("rst_mem_write",  {63'd0, mem_write},  64'd0);
    chk("rst_mem_addr",   mem_address,         64'd0);
    chk("rst_mem_wdata",  mem_write_data,      64'd0);
    rst = 1'b1;

    // LB @0x47: sign-extended top byte
    issue(1'b0, 3'b000, 64'h47, 64'd0);
    @(negedge clk);
    chk("lb_t1_mem_read",   {63'd0, mem_read},   64'd1);
    chk("lb_t1_mem_write",  {63'd0, mem_write},  64'd0);
    chk("lb_t1_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("lb_t1_addr",       mem_address,         64'h47);
    @(negedge clk);
    chk("lb_t2_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("lb_t2_rdata",      resp_rdata,          64'hFFFF_FFFF_FFFF_FF88);
    chk("lb_t2_err",        {63'd0, resp_err},   64'd0);
    chk("lb_t2_mem_read",   {63'd0, mem_read},   64'd0);

    // LBU @0x47: zero-extended top byte
    issue(1'b0, 3'b100, 64'h47, 64'd0);
    @(negedge clk);
    chk("lbu_t1_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("lbu_t2_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("lbu_t2_rdata",      resp_rdata,          64'h88);

    // SH 0xBEEF @0x42: read-modify-write
    issue(1'b1, 3'b001, 64'h42, 64'h0000_0000_0000_BEEF);
    @(negedge clk);
    chk("sh_t1_mem_read",  {63'd0, mem_read},  64'd1);
    chk("sh_t1_mem_write", {63'd0, mem_write}, 64'd0);
    @(negedge clk);
    chk("sh_t2_mem_write",  {63'd0, mem_write},  64'd1);
    chk("sh_t2_mem_read",   {63'd0, mem_read},   64'd0);
    chk("sh_t2_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("sh_t2_err",        {63'd0, resp_err},   64'd0);
    chk("sh_t2_wdata",      mem_write_data,      64'h8877_6655_BEEF_2211);
    chk("sh_t2_rdata",      resp_rdata,          64'd0);
    @(negedge clk);
    chk("sh_mem_word",      mem[8],              64'h8877_6655_BEEF_2211);

    // LD @0x40 sees the merged word
    issue(1'b0, 3'b011, 64'h40, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("ld_t2_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("ld_t2_rdata",      resp_rdata,          64'h8877_6655_BEEF_2211);

    // SD @0x80: single write cycle, no read
    issue(1'b1, 3'b011, 64'h80, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("sd_t1_mem_write",  {63'd0, mem_write},  64'd1);
    chk("sd_t1_mem_read",   {63'd0, mem_read},   64'd0);
    chk("sd_t1_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("sd_t1_wdata",      mem_write_data,      64'h0123_4567_89AB_CDEF);
    chk("sd_t1_addr",       mem_address,         64'h80);
    @(negedge clk);
    chk("sd_t2_mem_write",  {63'd0, mem_write},  64'd0);
    chk("sd_t2_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("sd_mem_word",      mem[16],             64'h0123_4567_89AB_CDEF);

    // LW @0x42: misaligned error, no memory access
    issue(1'b0, 3'b010, 64'h42, 64'd0);
    @(negedge clk);
    chk("lwmis_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("lwmis_err",        {63'd0, resp_err},   64'd1);
    chk("lwmis_mem_read",   {63'd0, mem_read},   64'd0);
    chk("lwmis_mem_write",  {63'd0, mem_write},  64'd0);
    chk("lwmis_rdata",      resp_rdata,          64'd0);
    @(negedge clk);
    chk("lwmis_t2_valid",   {63'd0, resp_valid}, 64'd0);
    chk("lwmis_t2_ready",   {63'd0, req_ready},  64'd1);

    // Store funct3=100: illegal
    issue(1'b1, 3'b100, 64'h40, 64'h55);
    @(negedge clk);
    chk("st100_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("st100_err",        {63'd0, resp_err},   64'd1);
    chk("st100_mem_write",  {63'd0, mem_write},  64'd0);

    // Load funct3=111: illegal
    issue(1'b0, 3'b111, 64'h40, 64'd0);
    @(negedge clk);
    chk("ld111_err",        {63'd0, resp_err},   64'd1);
    chk("ld111_mem_read",   {63'd0, mem_read},   64'd0);

    // SB @0x41 with reset pulsed during MERGE
    issue(1'b1, 3'b000, 64'h41, 64'hAA);
    @(negedge clk);
    chk("sbrst_t1_mem_read", {63'd0, mem_read},  64'd1);
    @(negedge clk);
    chk("sbrst_t2_mem_write", {63'd0, mem_write}, 64'd1);
    rst = 1'b0;
    #1;
    chk("sbrst_write_drop",  {63'd0, mem_write},  64'd0);
    chk("sbrst_no_resp",     {63'd0, resp_valid}, 64'd0);
    chk("sbrst_addr_clear",  mem_address,         64'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("sbrst_mem_word",    mem[8],              64'h8877_6655_BEEF_2211);
    @(negedge clk);
    chk("sbrst_ready",       {63'd0, req_ready},  64'd1);
    chk("sbrst_mem_word2",   mem[8],              64'h8877_6655_BEEF_2211);

    // Back-to-back LW, SB, LD with req_valid held high
    chk("b2b_lw_ready", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 64'h44;
    req_wdata  = 64'd0;
    @(negedge clk);
    chk("b2b_lw_t1_ready", {63'd0, req_ready},  64'd0);
    chk("b2b_lw_t1_read",  {63'd0, mem_read},   64'd1);
    chk("b2b_lw_t1_valid", {63'd0, resp_valid}, 64'd0);
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 64'h45;
    req_wdata  = 64'h5A;
    @(negedge clk);
    chk("b2b_lw_t2_valid", {63'd0, resp_valid}, 64'd1);
    chk("b2b_lw_t2_rdata", resp_rdata,          64'hFFFF_FFFF_8877_6655);
    chk("b2b_lw_t2_addr",  mem_address,         64'h44);
    chk("b2b_lw_t2_ready", {63'd0, req_ready},  64'd0);
    @(negedge clk);
    chk("b2b_sb_ready",    {63'd0, req_ready},  64'd1);
    chk("b2b_idle_valid",  {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("b2b_sb_t1_read",  {63'd0, mem_read},   64'd1);
    chk("b2b_sb_t1_addr",  mem_address,         64'h45);
    chk("b2b_sb_t1_valid", {63'd0, resp_valid}, 64'd0);
    req_we     = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = 64'h40;
    req_wdata  = 64'd0;
    @(negedge clk);
    chk("b2b_sb_t2_write", {63'd0, mem_write},  64'd1);
    chk("b2b_sb_t2_valid", {63'd0, resp_valid}, 64'd1);
    chk("b2b_sb_t2_wdata", mem_write_data,      64'h8877_5A55_BEEF_2211);
    @(negedge clk);
    chk("b2b_ld_ready",    {63'd0, req_ready},  64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_ld_t1_read",  {63'd0, mem_read},   64'd1);
    chk("b2b_ld_t1_valid", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    chk("b2b_ld_t2_valid", {63'd0, resp_valid}, 64'd1);
    chk("b2b_ld_t2_rdata", resp_rdata,          64'h8877_5A55_BEEF_2211);
    @(negedge clk);
    chk("b2b_end_ready",   {63'd0, req_ready},  64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: pipeline MEM-stage request present.
REQ-005 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV64I size/sign code.
REQ-008 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-009 SHALL have port req_wdata, input, 64: store data, right-justified.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 64: extended load result (0 for stores and errors).
REQ-012 SHALL have port resp_err, output, 1: misaligned or illegal funct3; qualified by resp_valid.
REQ-013 SHALL have ports mem_address (output, 64), mem_write_data (output, 64), mem_read (output, 1), mem_write (output, 1) and mem_read_data (input, 64), connecting to the data memory.

Function
REQ-014 SHALL assert req_ready only in state IDLE; a request is accepted on a cycle T with req_valid && req_ready, latching we, funct3, addr and wdata.
REQ-015 SHALL use states IDLE, RD, LDRESP, MERGE, WR, ERR.
REQ-016 SHALL define sizes as: funct3[1:0] 00=1 B, 01=2 B, 10=4 B, 11=8 B; loads with funct3[2]=1 zero-extend, otherwise sign-extend.
REQ-017 SHALL treat as illegal: load funct3=111; store funct3[2]=1.
REQ-018 SHALL treat as misaligned any addr[2:0] that is not a multiple of the access size.
REQ-019 SHALL, for an illegal or misaligned request, go IDLE->ERR, pulse resp_valid=1 and resp_err=1 in T+1, issue no mem_read/mem_write, then return to IDLE.
REQ-020 SHALL, for a load, go IDLE->RD (T+1: mem_read=1) ->LDRESP (T+2: resp_valid=1, resp_rdata formed combinationally from mem_read_data) ->IDLE.
REQ-021 SHALL, for an 8-byte store, go IDLE->WR (T+1: mem_write=1, mem_write_data=wdata, resp_valid=1) ->IDLE.
REQ-022 SHALL, for a 1/2/4-byte store, go IDLE->RD (T+1: mem_read=1) ->MERGE (T+2: mem_write=1, resp_valid=1) ->IDLE.
REQ-023 SHALL, in MERGE, write mem_read_data with only bytes [off, off+size-1] replaced by the low bytes of wdata, where off=addr[2:0].
REQ-024 SHALL use little-endian lanes: byte k occupies bits [8k+7:8k].
REQ-025 SHALL drive mem_address with the latched byte address (the memory divides by 8) and hold it constant from T+1 until return to IDLE.
REQ-026 SHALL extract load data as bytes starting at lane off, extended to 64 bits per REQ-016.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle; both SHALL be 0 in IDLE and ERR.
REQ-028 SHALL ignore req_valid outside IDLE; the requester holds the request until req_ready.
REQ-029 SHALL give resp_err=0 on every non-error completion.

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, latched registers=0, and therefore req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
REQ-031 SHALL, on reset asserted mid-operation (RD/MERGE/WR), deassert mem_write immediately, issue no write, and produce no response.

Structure
REQ-032 SHALL place the state enum and the funct3 constants (LB..LWU, SB..SD) in shared package mau_pkg.
REQ-033 SHALL implement extract/extend and merge as one combinational sub-module, mau_lane_align.
REQ-034 SHALL derive all outputs from the registered state and latched registers, plus mem_read_data in LDRESP/MERGE.

Verification
REQ-035 SHALL cover: memory word at 0x40 = 0x8877665544332211; LB @0x47 -> resp_rdata=0xFFFFFFFFFFFFFF88 at T+2; LBU @0x47 -> 0x88.
REQ-036 SHALL cover: same word; SH 0xBEEF @0x42 -> MERGE writes 0x88776655BEEF2211; a following LD @0x40 returns that value.
REQ-037 SHALL cover: SD 0x0123456789ABCDEF @0x80 -> mem_write in T+1 only, no mem_read, resp_valid at T+1.
REQ-038 SHALL cover: LW @0x42 -> resp_err=1 at T+1, with no memory access; store funct3=100 -> resp_err=1.
REQ-039 SHALL cover: rst pulsed low during MERGE of SB -> mem_write=0, memory unchanged, req_ready=1 after release.
REQ-040 SHALL cover: req_valid held high for back-to-back LW, SB, LD -> each accepted only in IDLE; responses in order with latencies 2, 2, 2.
